// File: rtl/aes_pkg.sv
// Shared AES-128 constants: round count, Rcon table, key-schedule FSM states and the S-box.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_e;

    // Byte 0 of the table sits at bits [0:7], so entry x lives at [8x +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single combinational AES S-box lookup, one byte in, one byte out.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = sbox(byte_i);

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..NR over valid/ready, SubWord done one byte per cycle.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [0:KW-1] key_in,
    output logic [0:KW-1] rk_out,
    output logic [0:3]    rk_idx,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          busy,
    output logic          done
);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [0:31] w0_q, w1_q, w2_q, w3_q, temp_q;
    logic [0:3]  idx_q;
    logic        done_q;

    logic [7:0]  sb_in, sb_out;
    logic [0:31] t_d, w0_d, w1_d, w2_d, w3_d;

    // Byte cnt of RotWord(w3) is byte (cnt+1) mod 4 of w3.
    always_comb begin
        sb_in = w3_q[0:7];
        case (cnt_q)
            2'd0:    sb_in = w3_q[8:15];
            2'd1:    sb_in = w3_q[16:23];
            2'd2:    sb_in = w3_q[24:31];
            default: sb_in = w3_q[0:7];
        endcase
    end

    aes_sbox_byte u_sbox (
        .byte_i (sb_in),
        .byte_o (sb_out)
    );

    always_comb begin
        t_d  = temp_q ^ {rcon(idx_q + 4'd1), 24'h000000};
        w0_d = w0_q ^ t_d;
        w1_d = w1_q ^ w0_d;
        w2_d = w2_q ^ w1_d;
        w3_d = w3_q ^ w2_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            temp_q  <= '0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        w0_q    <= key_in[0:31];
                        w1_q    <= key_in[32:63];
                        w2_q    <= key_in[64:95];
                        w3_q    <= key_in[96:127];
                        idx_q   <= 4'd0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (idx_q == 4'(NR)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= 2'd0;
                            state_q <= SUB;
                        end
                    end
                end
                SUB: begin
                    temp_q[{cnt_q, 3'b000} +: 8] <= sb_out;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= MIX;
                end
                MIX: begin
                    w0_q    <= w0_d;
                    w1_q    <= w1_d;
                    w2_q    <= w2_d;
                    w3_q    <= w3_d;
                    idx_q   <= idx_q + 4'd1;
                    state_q <= EMIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_out   = {w0_q, w1_q, w2_q, w3_q};
    assign rk_idx   = idx_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
